dmem_arbiter: RTL

Front-end arbiter for the CPU data RAM, a 256×8 simple dual-port block RAM with a write port (A) and a registered read port (B). Two masters share the RAM: the CPU load/store unit and the host loader/debug port. The arbiter arbitrates each RAM port independently, returns each read to the master that issued it, and forwards write data when a read and a write hit the same address in the same cycle. It sits directly upstream of the data RAM and drives all of that RAM's port signals.

---
 rtl/dmem_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-master (CPU, loader) arbiter for a simple dual-port data RAM, with per-port anti-starvation.
// Latency: grants are combinational; read data returns exactly one cycle after the read grant.
// Backpressure: a denied request is held by its master (cpu_stall high, or ld_ready low).
module dmem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    input  logic          cpu_re,
    output logic          cpu_stall,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    input  logic          ld_we,
    input  logic          ld_re,
    output logic          ld_ready,
    output logic [DW-1:0] ld_rdata,
    output logic          ld_rvalid,
    output logic [AW-1:0] ram_ada,
    output logic [DW-1:0] ram_din,
    output logic          ram_cea,
    output logic [AW-1:0] ram_adb,
    output logic          ram_ceb,
    output logic          ram_oce,
    output logic          ram_rst,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_LD   = 2'd2;
    localparam logic [3:0] SMAX     = 4'(STARVE_MAX);

    logic [3:0]    wstarve, rstarve;
    logic [1:0]    rd_own;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [DW-1:0] ret_data;

    logic cpu_wreq, ld_wreq, cpu_rreq, ld_rreq;
    logic cpu_wg, ld_wg, cpu_rg, ld_rg;

    // A master asserting both we and re is treated as a write; its read is dropped.
    assign cpu_wreq = cpu_we & ~rst;
    assign ld_wreq  = ld_we & ~rst;
    assign cpu_rreq = cpu_re & ~cpu_we & ~rst;
    assign ld_rreq  = ld_re & ~ld_we & ~rst;

    assign ld_wg  = ld_wreq & (~cpu_wreq | (wstarve == SMAX));
    assign cpu_wg = cpu_wreq & ~ld_wg;
    assign ld_rg  = ld_rreq & (~cpu_rreq | (rstarve == SMAX));
    assign cpu_rg = cpu_rreq & ~ld_rg;

    assign cpu_stall = cpu_we ? (cpu_wreq & ~cpu_wg) : (cpu_rreq & ~cpu_rg);
    assign ld_ready  = ld_wg | ld_rg;

    assign ram_cea = cpu_wg | ld_wg;
    assign ram_ada = ld_wg ? ld_addr  : (cpu_wg ? cpu_addr  : '0);
    assign ram_din = ld_wg ? ld_wdata : (cpu_wg ? cpu_wdata : '0);
    assign ram_ceb = cpu_rg | ld_rg;
    assign ram_adb = ld_rg ? ld_addr  : (cpu_rg ? cpu_addr  : '0);
    assign ram_oce = 1'b1;
    assign ram_rst = rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            wstarve  <= '0;
            rstarve  <= '0;
            rd_own   <= OWN_NONE;
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else begin
            if (!ld_wreq || ld_wg)
                wstarve <= '0;
            else if (wstarve != SMAX)
                wstarve <= wstarve + 4'd1;

            if (!ld_rreq || ld_rg)
                rstarve <= '0;
            else if (rstarve != SMAX)
                rstarve <= rstarve + 4'd1;

            rd_own   <= ld_rg ? OWN_LD : (cpu_rg ? OWN_CPU : OWN_NONE);
            // The RAM read port returns pre-write data on a same-address collision.
            fwd_hit  <= ram_cea & ram_ceb & (ram_ada == ram_adb);
            fwd_data <= ram_din;
        end
    end

    assign ret_data   = fwd_hit ? fwd_data : ram_dout;
    assign cpu_rvalid = (rd_own == OWN_CPU);
    assign ld_rvalid  = (rd_own == OWN_LD);
    assign cpu_rdata  = cpu_rvalid ? ret_data : '0;
    assign ld_rdata   = ld_rvalid  ? ret_data : '0;

endmodule
